// File: rtl/prefix_pkg.sv
// Shared types for the 16-bit parallel-prefix adder carry network.
// Vector width, level count and the per-stage propagate/generate bundle.
package prefix_pkg;

  localparam int PFX_WIDTH  = 17;
  localparam int PFX_LEVELS = 5;

  typedef logic [PFX_WIDTH-1:0] pg_vec_t;

  typedef struct packed {
    pg_vec_t g;
    pg_vec_t p;
    pg_vec_t p_orig;
  } pfx_stage_t;

endpackage

// File: rtl/prefix_network_pipe_16b_cell.sv
// prefix_cell: Kogge-Stone black cell combining a high and a low span.
// Ports: g_hi/p_hi, g_lo/p_lo in; combined g/p out.
module prefix_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);

  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;

endmodule

// File: rtl/prefix_network_pipe_16b.sv
// Pipelined Kogge-Stone carry network: prop_i/gen_i in, carry_o/prop_o out,
// valid/ready on both sides; REG_MASK picks registered levels.
// Optional PREFIX_STALL_CNT_EN adds stall_cnt_o (saturating stall count).
module prefix_network_pipe_16b
  import prefix_pkg::*;
#(
  parameter logic [PFX_LEVELS-1:0] REG_MASK = 5'b10010
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [PFX_WIDTH-1:0] prop_i,
  input  logic [PFX_WIDTH-1:0] gen_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [PFX_WIDTH-1:0] carry_o,
  output logic [PFX_WIDTH-1:0] prop_o
`ifdef PREFIX_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt_o
`endif
);

  // d/v flow forward, r flows backward; index n = after level n.
  pfx_stage_t d [0:PFX_LEVELS];
  logic       v [0:PFX_LEVELS];
  logic       r [0:PFX_LEVELS];

  assign d[0].g      = gen_i;
  assign d[0].p      = prop_i;
  assign d[0].p_orig = prop_i;
  assign v[0]        = valid_i;
  assign r[PFX_LEVELS] = ready_i;

  genvar n, i;
  for (n = 1; n <= PFX_LEVELS; n++) begin : g_lvl
    localparam int D = 1 << (n - 1);
    pfx_stage_t c;

    assign c.p_orig = d[n-1].p_orig;

    for (i = 0; i < PFX_WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_cell
        prefix_cell u_cell (
          .g_hi (d[n-1].g[i]),
          .p_hi (d[n-1].p[i]),
          .g_lo (d[n-1].g[i-D]),
          .p_lo (d[n-1].p[i-D]),
          .g    (c.g[i]),
          .p    (c.p[i])
        );
      end else begin : g_pass
        assign c.g[i] = d[n-1].g[i];
        assign c.p[i] = d[n-1].p[i];
      end
    end

    if (REG_MASK[n-1]) begin : g_reg
      pfx_stage_t q;
      logic       vq;
      logic       en;

      // Empty stage or draining stage may load: bubbles collapse.
      assign en = ~vq | r[n];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          q  <= '0;
          vq <= 1'b0;
        end else if (en) begin
          q  <= c;
          vq <= v[n-1];
        end
      end

      assign d[n]   = q;
      assign v[n]   = vq;
      assign r[n-1] = en;
    end else begin : g_comb
      assign d[n]   = c;
      assign v[n]   = v[n-1];
      assign r[n-1] = r[n];
    end
  end

  assign valid_o = v[PFX_LEVELS];
  assign ready_o = r[0];
  assign carry_o = d[PFX_LEVELS].g;
  assign prop_o  = d[PFX_LEVELS].p_orig;

`ifdef PREFIX_STALL_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (valid_o && !ready_i && stall_cnt_o != 16'hFFFF) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule
